// File: rtl/id_emitter_if.sv
// Byte-stream and run-control bundle between id_emitter (master) and its consumer (slave).
interface id_emitter_if;
  logic       start;
  logic [7:0] count;
  logic [7:0] letter;
  logic       ready;
  logic [7:0] char;
  logic       valid;
  logic       busy;
  logic       done;

  modport master (
    input  start, count, letter, ready,
    output char, valid, busy, done
  );

  modport slave (
    output start, count, letter, ready,
    input  char, valid, busy, done
  );
endinterface

// File: rtl/id_emitter.sv
// Emits COUNT identifiers "<prefix letters><fixed-width decimal index>" each followed by a
// separator byte, as a valid/ready byte stream with registered outputs.
module id_emitter #(
  parameter int unsigned PREFIX_LEN = 2,
  parameter int unsigned DIGITS     = 3,
  parameter logic [7:0]  SEP        = 8'd32
) (
  input logic          i_clk,
  input logic          i_reset,
  id_emitter_if.master io_bus
);

  typedef enum logic [1:0] {StIdle, StPref, StNum, StSep} state_e;

  state_e                   r_state, w_state_d;
  logic [2:0]               r_pos, w_pos_d;
  logic [7:0]               r_count, w_count_d;
  logic [7:0]               r_letter, w_letter_d;
  logic [DIGITS-1:0][3:0]   r_idx, w_idx_d, w_idx_inc;
  logic [7:0]               r_char, w_char_d;
  logic                     r_valid, w_valid_d;
  logic                     r_busy, w_busy_d;
  logic                     r_done, w_done_d;
  logic                     w_beat, w_start_run, w_start_nil;
  logic                     w_pref_last, w_num_last, w_run_last, w_carry;

  function automatic logic is_letter(logic [7:0] c);
    return (c >= 8'h41 && c <= 8'h5a) || (c >= 8'h61 && c <= 8'h7a);
  endfunction

  // Output byte for a given position; ltr is already sanitized to a letter.
  function automatic logic [7:0] char_of(state_e st, logic [2:0] pos, logic [7:0] ltr,
                                         logic [DIGITS-1:0][3:0] idx);
    logic [7:0] base, off;
    char_of = 8'd0;
    base    = (ltr >= 8'h61) ? 8'h61 : 8'h41;
    off     = ltr - base + {5'd0, pos};
    if (off >= 8'd26) off = off - 8'd26;
    case (st)
      StPref: char_of = base + off;
      StNum: begin
        for (int i = 0; i < int'(DIGITS); i++) begin
          if (int'(pos) == int'(DIGITS) - 1 - i) char_of = 8'h30 + {4'd0, idx[i]};
        end
      end
      StSep:   char_of = SEP;
      default: char_of = 8'd0;
    endcase
  endfunction

  assign w_beat      = r_valid & io_bus.ready;
  assign w_start_run = (r_state == StIdle) && io_bus.start && (io_bus.count != 8'd0);
  assign w_start_nil = (r_state == StIdle) && io_bus.start && (io_bus.count == 8'd0);
  assign w_pref_last = (r_pos == 3'(PREFIX_LEN - 1));
  assign w_num_last  = (r_pos == 3'(DIGITS - 1));
  assign w_run_last  = (r_count == 8'd1);

  // BCD increment, LSD first; 9s roll to 0 and pass the carry on.
  always_comb begin
    w_idx_inc = r_idx;
    w_carry   = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (w_carry) begin
        if (r_idx[i] == 4'd9) begin
          w_idx_inc[i] = 4'd0;
        end else begin
          w_idx_inc[i] = r_idx[i] + 4'd1;
          w_carry      = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= StIdle;
    else         r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:  if (w_start_run) w_state_d = StPref;
      StPref:  if (w_beat && w_pref_last) w_state_d = StNum;
      StNum:   if (w_beat && w_num_last) w_state_d = StSep;
      StSep:   if (w_beat) w_state_d = w_run_last ? StIdle : StPref;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_count_d  = r_count;
    w_letter_d = r_letter;
    w_idx_d    = r_idx;
    if (w_state_d != r_state) w_pos_d = 3'd0;
    else if (w_beat)          w_pos_d = r_pos + 3'd1;
    else                      w_pos_d = r_pos;
    if (w_start_run) begin
      w_count_d  = io_bus.count;
      w_letter_d = is_letter(io_bus.letter) ? io_bus.letter : 8'h61;
      w_idx_d    = '0;
    end else if (r_state == StSep && w_beat) begin
      w_count_d = r_count - 8'd1;
      w_idx_d   = w_idx_inc;
    end
  end

  // Outputs are registered: compute the value they take after this edge.
  always_comb begin
    w_valid_d = (w_state_d != StIdle);
    w_busy_d  = w_valid_d;
    w_char_d  = char_of(w_state_d, w_pos_d, w_letter_d, w_idx_d);
    w_done_d  = w_start_nil || (r_state == StSep && w_beat && w_run_last);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pos    <= 3'd0;
      r_count  <= 8'd0;
      r_letter <= 8'd0;
      r_idx    <= '0;
      r_char   <= 8'd0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_pos    <= w_pos_d;
      r_count  <= w_count_d;
      r_letter <= w_letter_d;
      r_idx    <= w_idx_d;
      r_char   <= w_char_d;
      r_valid  <= w_valid_d;
      r_busy   <= w_busy_d;
      r_done   <= w_done_d;
    end
  end

  assign io_bus.char  = r_char;
  assign io_bus.valid = r_valid;
  assign io_bus.busy  = r_busy;
  assign io_bus.done  = r_done;

endmodule

// File: tb/tb_id_emitter.sv
// Bench for id_emitter (PREFIX_LEN=2, DIGITS=2): expected byte streams come from a
// string-level model of the identifier format; ready is driven directed or random.
module tb_id_emitter;
  localparam int PL = 2;
  localparam int DG = 2;
  localparam logic [7:0] SEPB = 8'd32;

  logic clk;
  logic reset;
  id_emitter_if bus ();

  id_emitter #(.PREFIX_LEN(PL), .DIGITS(DG), .SEP(SEPB)) dut (
    .i_clk  (clk),
    .i_reset(reset),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  function automatic logic [7:0] pref_char(input logic [7:0] ltr, input int k);
    int b;
    int l;
    l = int'(ltr);
    if (l >= 97 && l <= 122)     b = 97;
    else if (l >= 65 && l <= 90) b = 65;
    else begin b = 97; l = 97; end
    return 8'(b + (l - b + k) % 26);
  endfunction

  function automatic void build(input int cnt, input logic [7:0] ltr);
    int idx, p;
    for (int n = 0; n < cnt; n++) begin
      for (int k = 0; k < PL; k++) exp_q.push_back(pref_char(ltr, k));
      idx = n % (10 ** DG);
      for (int d = DG - 1; d >= 0; d--) begin
        p = 10 ** d;
        exp_q.push_back(8'(48 + (idx / p) % 10));
      end
      exp_q.push_back(SEPB);
    end
  endfunction

  // mode 0: ready=1; mode 1: random ready; mode 2: 5-cycle stall before beat 3 (mid-number).
  task automatic run(input int cnt, input logic [7:0] ltr, input int mode, input bit poke);
    int beats, guard, hold, budget;
    logic [7:0] prev_char;
    logic prev_valid, prev_ready;
    exp_q.delete();
    build(cnt, ltr);
    budget = 20 * exp_q.size() + 50;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.count  = 8'(cnt);
    bus.letter = ltr;
    bus.ready  = 1'b0;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.count  = 8'($urandom);
    bus.letter = 8'($urandom);
    if (cnt == 0) begin
      check("nil_done", {31'd0, bus.done}, 32'd1);
      check("nil_valid", {31'd0, bus.valid}, 32'd0);
      check("nil_busy", {31'd0, bus.busy}, 32'd0);
      @(negedge clk);
      check("nil_done_clr", {31'd0, bus.done}, 32'd0);
      return;
    end
    beats = 0; guard = 0; hold = 0;
    prev_valid = 1'b0; prev_ready = 1'b1; prev_char = 8'd0;
    while (exp_q.size() > 0 && guard < budget) begin
      check("valid_high", {31'd0, bus.valid}, 32'd1);
      check("busy_high", {31'd0, bus.busy}, 32'd1);
      if (prev_valid && !prev_ready) check("stall_hold", {24'd0, bus.char}, {24'd0, prev_char});
      case (mode)
        0: bus.ready = 1'b1;
        1: bus.ready = 1'($urandom_range(0, 1));
        default: begin
          bus.ready = !(beats == 3 && hold < 5);
          if (!bus.ready) hold++;
        end
      endcase
      bus.start = poke && (beats == 6);
      if (bus.valid && bus.ready) begin
        check($sformatf("beat%0d", beats), {24'd0, bus.char}, {24'd0, exp_q.pop_front()});
        beats++;
      end
      prev_valid = bus.valid; prev_ready = bus.ready; prev_char = bus.char;
      @(negedge clk);
      guard++;
    end
    bus.start = 1'b0;
    bus.ready = 1'b0;
    check("stream_complete", exp_q.size(), 32'd0);
    check("end_done", {31'd0, bus.done}, 32'd1);
    check("end_valid", {31'd0, bus.valid}, 32'd0);
    check("end_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    check("done_clr", {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.count = 8'd0; bus.letter = 8'd0; bus.ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_char", {24'd0, bus.char}, 32'd0);
    check("rst_valid", {31'd0, bus.valid}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run(3, 8'h78, 0, 1'b0);   // 'x'
    run(2, 8'h7a, 0, 1'b0);   // 'z' -> "za"
    run(2, 8'h59, 1, 1'b0);   // 'Y' -> "YZ"
    run(2, 8'h35, 0, 1'b0);   // '5' -> "ab"
    run(3, 8'h6b, 2, 1'b0);   // stall mid-number
    run(0, 8'h41, 0, 1'b0);   // no identifiers
    run(3, 8'h51, 0, 1'b1);   // start while busy ignored
    run(102, 8'h6d, 1, 1'b0); // index wraps 99 -> 00

    // Reset during the 2nd identifier, then restart from index 00.
    @(negedge clk);
    bus.start = 1'b1; bus.count = 8'd3; bus.letter = 8'h78; bus.ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    check("mid_valid_pre", {31'd0, bus.valid}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", {31'd0, bus.valid}, 32'd0);
    check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    check("mid_rst_done", {31'd0, bus.done}, 32'd0);
    reset = 1'b0;
    bus.ready = 1'b0;
    @(negedge clk);
    check("post_rst_done", {31'd0, bus.done}, 32'd0);
    run(2, 8'h78, 0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      run(int'($urandom_range(1, 6)), 8'($urandom), 1, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
